// File: rtl/io_pkg.sv
// rtl/io_pkg.sv - shared encodings and defaults for the decimal input path
package io_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2,
    RESP = 2'd3
  } io_state_t;

  localparam int          IO_DW      = 16;
  localparam int          IO_TO_W    = 16;
  localparam logic [15:0] IO_TIMEOUT = 16'hFFFF;

  // Index width for an n-entry one-hot vector; never below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin picker starting after the last owner
module rr_pick
  import io_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IW   = idx_w(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);

  logic [IW-1:0] cand;

  // Scan ptr+1 .. ptr+NREQ so the previous owner is considered last.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = '0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = IW'((int'(ptr) + i) % NREQ);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/inp_arbiter.sv
// rtl/inp_arbiter.sv - round-robin arbiter sharing the input unit among requesters
module inp_arbiter
  import io_pkg::*;
#(
  parameter int              DW      = IO_DW,
  parameter int              NREQ    = 2,
  parameter int              TO_W    = IO_TO_W,
  parameter logic [TO_W-1:0] TIMEOUT = TO_W'(IO_TIMEOUT)
) (
  input  logic            clk,
  input  logic            rst_b,
  input  logic [NREQ-1:0] cli_req,
  output logic [NREQ-1:0] cli_ack,
  output logic [DW-1:0]   cli_data,
  output logic [NREQ-1:0] grant,
  output logic            busy,
  output logic            timeout_err,
  output logic            inp_req,
  input  logic            inp_ack,
  input  logic [DW-1:0]   inp_data
);

  localparam int IW = idx_w(NREQ);

  io_state_t       state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   own_q, own_d;
  logic [TO_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]   data_q, data_d;
  logic [NREQ-1:0] cli_ack_d;
  logic [DW-1:0]   cli_data_d;
  logic [NREQ-1:0] grant_d;
  logic            busy_d;
  logic            timeout_err_d;
  logic            inp_req_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;

  rr_pick #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_pick (
    .req (cli_req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  always_comb begin
    state_d       = state_q;
    ptr_d         = ptr_q;
    own_d         = own_q;
    cnt_d         = cnt_q;
    data_d        = data_q;
    cli_ack_d     = cli_ack;
    cli_data_d    = cli_data;
    grant_d       = grant;
    busy_d        = busy;
    timeout_err_d = timeout_err;
    inp_req_d     = inp_req;

    case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d       = pick_gnt;
          own_d         = pick_idx;
          inp_req_d     = 1'b1;
          busy_d        = 1'b1;
          timeout_err_d = 1'b0;
          cnt_d         = '0;
          state_d       = REQ;
        end
      end

      REQ: begin
        if (inp_ack) begin
          data_d    = inp_data;
          inp_req_d = 1'b0;
          state_d   = DROP;
        end else if (cnt_q == TIMEOUT - TO_W'(1)) begin
          // Unit never answered: finish the transaction with a zero result.
          data_d        = '0;
          inp_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          state_d       = DROP;
        end else if (cnt_q != {TO_W{1'b1}}) begin
          cnt_d = cnt_q + TO_W'(1);
        end
      end

      DROP: begin
        if (!inp_ack) begin
          if (cli_req[own_q]) begin
            cli_ack_d        = '0;
            cli_ack_d[own_q] = 1'b1;
            cli_data_d       = data_q;
            state_d          = RESP;
          end else begin
            // Owner already withdrew; result is discarded.
            grant_d = '0;
            ptr_d   = own_q;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end

      RESP: begin
        if (!cli_req[own_q]) begin
          cli_ack_d = '0;
          grant_d   = '0;
          ptr_d     = own_q;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= IDLE;
      ptr_q       <= IW'(NREQ - 1);
      own_q       <= '0;
      cnt_q       <= '0;
      data_q      <= '0;
      cli_ack     <= '0;
      cli_data    <= '0;
      grant       <= '0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
      inp_req     <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      cnt_q       <= cnt_d;
      data_q      <= data_d;
      cli_ack     <= cli_ack_d;
      cli_data    <= cli_data_d;
      grant       <= grant_d;
      busy        <= busy_d;
      timeout_err <= timeout_err_d;
      inp_req     <= inp_req_d;
    end
  end

endmodule

// File: tb/tb_inp_arbiter.sv
// tb/tb_inp_arbiter.sv - self-checking bench for inp_arbiter with a small input-unit model
module tb_inp_arbiter;

  localparam int DW   = 16;
  localparam int NREQ = 4;
  localparam int TO_W = 8;
  localparam int TMO  = 8;

  logic            clk = 1'b0;
  logic            rst_b = 1'b0;
  logic [NREQ-1:0] cli_req = '0;
  logic [NREQ-1:0] cli_ack;
  logic [DW-1:0]   cli_data;
  logic [NREQ-1:0] grant;
  logic            busy;
  logic            timeout_err;
  logic            inp_req;
  logic            inp_ack = 1'b0;
  logic [DW-1:0]   inp_data = '0;

  int checks = 0;
  int errors = 0;
  int ptr_m  = NREQ - 1;

  typedef struct {
    logic [NREQ-1:0] req;
    int              delay;
    logic [DW-1:0]   val;
    bit              stuck;
    int              owner;
    logic [DW-1:0]   data;
  } vec_t;

  vec_t tbl[10];

  inp_arbiter #(
    .DW      (DW),
    .NREQ    (NREQ),
    .TO_W    (TO_W),
    .TIMEOUT (8'd8)
  ) dut (
    .clk         (clk),
    .rst_b       (rst_b),
    .cli_req     (cli_req),
    .cli_ack     (cli_ack),
    .cli_data    (cli_data),
    .grant       (grant),
    .busy        (busy),
    .timeout_err (timeout_err),
    .inp_req     (inp_req),
    .inp_ack     (inp_ack),
    .inp_data    (inp_data)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_wait(input string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired", name);
  endtask

  // Spec rule: first requester strictly after the last owner, wrapping around.
  function automatic int model_pick(input logic [NREQ-1:0] r, input int p);
    for (int d = 1; d <= NREQ; d++)
      if (r[(p + d) % NREQ]) return (p + d) % NREQ;
    return -1;
  endfunction

  task automatic wait_inp_req(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (inp_req) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) fail_wait("wait_inp_req");
  endtask

  task automatic run_txn(input logic [NREQ-1:0] req, input int delay, input logic [DW-1:0] val,
                         input bit stuck, input int owner, input logic [DW-1:0] data);
    bit ok;
    int n;
    cli_req = req;
    wait_inp_req(ok);
    if (!ok) begin
      cli_req = '0;
      return;
    end
    chk("grant", 32'(grant), 32'(1) << owner);
    chk("busy", 32'(busy), 32'd1);
    chk("terr_clear", 32'(timeout_err), 32'd0);
    if (stuck) begin
      inp_data = 16'hBEEF;
      n = 1;
      while (n < 40) begin
        @(negedge clk);
        if (!inp_req) break;
        n++;
      end
      chk("timeout_len", 32'(n), 32'(TMO));
    end else begin
      repeat (delay) @(negedge clk);
      inp_ack  = 1'b1;
      inp_data = val;
      @(negedge clk);
      chk("ack_req_low", 32'(inp_req), 32'd0);
      inp_ack  = 1'b0;
      inp_data = 16'hDEAD;
    end
    n = 0;
    while (n < 10 && cli_ack == '0) begin
      @(negedge clk);
      n++;
    end
    chk("resp_lat", 32'(n), 32'd1);
    chk("cli_ack", 32'(cli_ack), 32'(1) << owner);
    chk("cli_data", 32'(cli_data), 32'(data));
    chk("terr", 32'(timeout_err), 32'(stuck));
    chk("grant_resp", 32'(grant), 32'(1) << owner);
    cli_req[owner] = 1'b0;
    @(negedge clk);
    chk("ack_drop", 32'(cli_ack), 32'd0);
    chk("grant_idle", 32'(grant), 32'd0);
    chk("busy_idle", 32'(busy), 32'd0);
    chk("data_hold", 32'(cli_data), 32'(data));
    ptr_m = owner;
  endtask

  initial begin
    bit ok;
    bit seen;
    logic [NREQ-1:0] r;
    logic [DW-1:0] v;
    bit st;
    int o;

    tbl[0] = '{4'b0011, 0, 16'd5,    1'b0, 0, 16'd5};
    tbl[1] = '{4'b0011, 1, 16'd7,    1'b0, 1, 16'd7};
    tbl[2] = '{4'b0011, 2, 16'd9,    1'b0, 0, 16'd9};
    tbl[3] = '{4'b0011, 0, 16'd11,   1'b0, 1, 16'd11};
    tbl[4] = '{4'b0001, 3, 16'd1234, 1'b0, 0, 16'd1234};
    tbl[5] = '{4'b1000, 1, 16'd3,    1'b0, 3, 16'd3};
    tbl[6] = '{4'b1001, 0, 16'd42,   1'b0, 0, 16'd42};
    tbl[7] = '{4'b1001, 2, 16'd43,   1'b0, 3, 16'd43};
    tbl[8] = '{4'b0100, 0, 16'd0,    1'b1, 2, 16'd0};
    tbl[9] = '{4'b0110, 3, 16'd77,   1'b0, 1, 16'd77};

    repeat (2) @(negedge clk);
    chk("rst_cli_ack", 32'(cli_ack), 32'd0);
    chk("rst_cli_data", 32'(cli_data), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    chk("rst_inp_req", 32'(inp_req), 32'd0);
    rst_b = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);

    for (int i = 0; i < 10; i++)
      run_txn(tbl[i].req, tbl[i].delay, tbl[i].val, tbl[i].stuck, tbl[i].owner, tbl[i].data);

    for (int i = 0; i < 40; i++) begin
      r  = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      v  = DW'($urandom);
      st = ($urandom_range(0, 7) == 0);
      o  = model_pick(r, ptr_m);
      run_txn(r, $urandom_range(0, 4), v, st, o, st ? '0 : v);
    end

    // Owner withdraws during REQ: handshake completes, no response, pointer moves on.
    run_txn(4'b0010, 1, 16'h0101, 1'b0, model_pick(4'b0010, ptr_m), 16'h0101);
    cli_req = 4'b0100;
    wait_inp_req(ok);
    chk("wd_grant", 32'(grant), 32'b0100);
    cli_req = '0;
    repeat (2) @(negedge clk);
    inp_ack  = 1'b1;
    inp_data = 16'd55;
    @(negedge clk);
    inp_ack = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (cli_ack != '0) seen = 1'b1;
    end
    chk("wd_no_ack", 32'(seen), 32'd0);
    chk("wd_grant_idle", 32'(grant), 32'd0);
    chk("wd_busy_idle", 32'(busy), 32'd0);
    ptr_m = 2;
    run_txn(4'b0110, 0, 16'd66, 1'b0, model_pick(4'b0110, ptr_m), 16'd66);

    // Reset mid-REQ: outputs drop asynchronously and requester 0 wins afterwards.
    run_txn(4'b0001, 0, 16'd88, 1'b0, model_pick(4'b0001, ptr_m), 16'd88);
    cli_req = 4'b0010;
    wait_inp_req(ok);
    #2 rst_b = 1'b0;
    #1;
    chk("arst_inp_req", 32'(inp_req), 32'd0);
    chk("arst_grant", 32'(grant), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    cli_req = '0;
    @(negedge clk);
    rst_b = 1'b1;
    ptr_m = NREQ - 1;
    @(negedge clk);
    run_txn(4'b0011, 2, 16'd99, 1'b0, model_pick(4'b0011, ptr_m), 16'd99);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
